// File: rtl/alarm_controller_if.sv
// Bundle of the time inputs, UI controls and status outputs of alarm_controller.
//   master : time source / UI side (drives time and controls, reads status)
//   slave  : alarm_controller itself
//   sec/min/hr          current time, 24 h binary
//   set_en/set_hr/min   alarm-time load strobe and value
//   alarm_on/snooze/stop user levels
//   buzzer/state/alarm_hr/alarm_min/snooze_cnt/missed  status back to the UI
interface alarm_controller_if;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       set_en;
    logic [4:0] set_hr;
    logic [5:0] set_min;
    logic       alarm_on;
    logic       snooze;
    logic       stop;
    logic       buzzer;
    logic [1:0] state;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic [1:0] snooze_cnt;
    logic       missed;

    modport master (
        output sec, min, hr, set_en, set_hr, set_min, alarm_on, snooze, stop,
        input  buzzer, state, alarm_hr, alarm_min, snooze_cnt, missed
    );
    modport slave (
        input  sec, min, hr, set_en, set_hr, set_min, alarm_on, snooze, stop,
        output buzzer, state, alarm_hr, alarm_min, snooze_cnt, missed
    );
endinterface

// File: rtl/alarm_controller.sv
// Alarm controller fed by the 1 Hz digital_clock tick (one clk cycle = one second).
// Stores an alarm time, rings the buzzer at hh:mm:00, supports a bounded number
// of snoozes and auto-stops unanswered rings, flagging them as missed.
// Ports:
//   clk   1 Hz tick, rising edge
//   reset asynchronous, active high; clears all state
//   bus   alarm_controller_if.slave (time in, controls in, status out)
module alarm_controller #(
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_TIMEOUT = 60,
    parameter int MAX_SNOOZE   = 3
) (
    input logic               clk,
    input logic               reset,
    alarm_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        RINGING = 2'b10,
        SNOOZED = 2'b11
    } state_t;

    state_t     state_q, state_n;
    logic [4:0] alarm_hr_q, alarm_hr_n, tgt_hr_q, tgt_hr_n;
    logic [5:0] alarm_min_q, alarm_min_n, tgt_min_q, tgt_min_n;
    logic [1:0] snooze_cnt_q, snooze_cnt_n;
    logic [6:0] ring_cnt_q, ring_cnt_n;
    logic       missed_q, missed_n;
    logic       match_d_q;
    logic       buzzer_q, buzzer_n;

    // Snooze target = current hh:mm + SNOOZE_MIN, computed in 6 bits by
    // deciding the minute wrap before adding.
    logic       snz_wrap;
    logic [5:0] snz_min;
    logic [4:0] snz_hr;
    assign snz_wrap = bus.min >= 6'(60 - SNOOZE_MIN);
    assign snz_min  = snz_wrap ? bus.min - 6'(60 - SNOOZE_MIN) : bus.min + 6'(SNOOZE_MIN);
    assign snz_hr   = !snz_wrap       ? bus.hr :
                      (bus.hr == 5'd23) ? 5'd0 : bus.hr + 5'd1;

    // Only SNOOZED compares against the snooze time; every other state
    // watches the stored alarm time so match_d stays meaningful across
    // RINGING -> ARMED.
    logic [4:0] cmp_hr;
    logic [5:0] cmp_min;
    logic       match, trigger, set_ok;
    assign cmp_hr  = (state_q == SNOOZED) ? tgt_hr_q  : alarm_hr_q;
    assign cmp_min = (state_q == SNOOZED) ? tgt_min_q : alarm_min_q;
    assign match   = (bus.hr == cmp_hr) && (bus.min == cmp_min) && (bus.sec == 6'd0);
    assign trigger = match && !match_d_q;
    assign set_ok  = bus.set_en && (bus.set_hr <= 5'd23) && (bus.set_min <= 6'd59);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            alarm_hr_q   <= '0;
            alarm_min_q  <= '0;
            tgt_hr_q     <= '0;
            tgt_min_q    <= '0;
            snooze_cnt_q <= '0;
            ring_cnt_q   <= '0;
            missed_q     <= 1'b0;
            match_d_q    <= 1'b0;
            buzzer_q     <= 1'b0;
        end else begin
            state_q      <= state_n;
            alarm_hr_q   <= alarm_hr_n;
            alarm_min_q  <= alarm_min_n;
            tgt_hr_q     <= tgt_hr_n;
            tgt_min_q    <= tgt_min_n;
            snooze_cnt_q <= snooze_cnt_n;
            ring_cnt_q   <= ring_cnt_n;
            missed_q     <= missed_n;
            match_d_q    <= match;
            buzzer_q     <= buzzer_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        alarm_hr_n   = alarm_hr_q;
        alarm_min_n  = alarm_min_q;
        tgt_hr_n     = tgt_hr_q;
        tgt_min_n    = tgt_min_q;
        snooze_cnt_n = snooze_cnt_q;
        ring_cnt_n   = ring_cnt_q;
        missed_n     = missed_q;
        // A valid time is stored even while disabled; alarm_on=0 still wins
        // for the state itself.
        if (set_ok) begin
            alarm_hr_n  = bus.set_hr;
            alarm_min_n = bus.set_min;
        end
        if (!bus.alarm_on) begin
            state_n      = IDLE;
            snooze_cnt_n = '0;
            missed_n     = 1'b0;
        end else if (set_ok) begin
            state_n      = ARMED;
            snooze_cnt_n = '0;
            missed_n     = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_n = ARMED;
                ARMED: begin
                    if (trigger) begin
                        state_n    = RINGING;
                        ring_cnt_n = '0;
                    end
                end
                RINGING: begin
                    if (bus.stop) begin
                        state_n      = ARMED;
                        snooze_cnt_n = '0;
                    end else if (bus.snooze && snooze_cnt_q < 2'(MAX_SNOOZE)) begin
                        state_n      = SNOOZED;
                        snooze_cnt_n = snooze_cnt_q + 2'd1;
                        tgt_hr_n     = snz_hr;
                        tgt_min_n    = snz_min;
                    end else if (ring_cnt_q == 7'(RING_TIMEOUT - 1)) begin
                        state_n      = ARMED;
                        missed_n     = 1'b1;
                        snooze_cnt_n = '0;
                    end else begin
                        ring_cnt_n = ring_cnt_q + 7'd1;
                    end
                end
                SNOOZED: begin
                    if (bus.stop) begin
                        state_n      = ARMED;
                        snooze_cnt_n = '0;
                    end else if (trigger) begin
                        state_n    = RINGING;
                        ring_cnt_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Buzzer is registered off the next state so it follows RINGING exactly.
    always_comb begin
        buzzer_n = (state_n == RINGING);
    end

    assign bus.buzzer     = buzzer_q;
    assign bus.state      = state_q;
    assign bus.alarm_hr   = alarm_hr_q;
    assign bus.alarm_min  = alarm_min_q;
    assign bus.snooze_cnt = snooze_cnt_q;
    assign bus.missed     = missed_q;
endmodule
